if_fetch_ctrl: RTL and testbench



---
 rtl/if_fetch_ctrl_if.sv | 43 ++++
 rtl/if_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_if
//
// Purpose:
//   SRAM-like instruction port between the fetch sequencer and the AXI
//   bridge. The fetch sequencer holds one request at a time. It keeps
//   inst_req/inst_addr stable until the bridge answers with inst_addr_ok.
//   The bridge then returns one word with inst_data_ok.
//
// Signals:
//   inst_req      master->slave  request valid
//   inst_addr     master->slave  32-bit word-aligned fetch address
//   inst_addr_ok  slave->master  address accepted this cycle
//   inst_data_ok  slave->master  inst_rdata valid this cycle
//   inst_rdata    slave->master  32-bit instruction word
//
// Modports:
//   master  fetch sequencer side
//   slave   bridge side
// ---------------------------------------------------------------------------
interface if_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Purpose:
//   Instruction-fetch sequencer between the PC register and the SRAM-like
//   instruction port of the AXI bridge.
//   - It issues exactly one address/data transaction per PC.
//   - It asks the PC to hold (stallreq) while that transaction is open.
//   - It presents the returned word in a registered IF/ID-facing output.
//   - A flush that lands mid-transaction cannot retract the bus request.
//     The transaction therefore runs to completion, and its data is
//     thrown away.
//   - A PC flagged with an address error (AdEL) never reaches the bus. It
//     goes straight to the output register as a zero instruction that
//     carries the exception word.
//
// Parameters:
//   RESET_PC   value shown on if_pc after reset (if_valid is low then)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   stall      pipeline stall vector; stall[1] holds the IF output register
//   flush      exception flush; the PC loads its new value on the same edge
//   pc_ce      PC register holds a valid fetch address
//   pc         fetch address
//   pc_except  exception word; bit 16 flags a fetch address error
//   stallreq   freeze PC/IF until the current fetch completes
//   bus        instruction port (master modport of if_fetch_ctrl_if)
//   if_valid   if_pc/if_inst/if_except hold a valid fetched instruction
//   if_pc      PC of the held instruction
//   if_inst    instruction word
//   if_except  exception word travelling with the instruction
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfbf_fffc
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic                   pc_ce,
  input  logic [31:0]            pc,
  input  logic [31:0]            pc_except,
  output logic                   stallreq,
  if_fetch_ctrl_if.master        bus,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst,
  output logic [31:0]            if_except
);

  localparam int ADEL_BIT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic        cancel;
  logic        inst_req_r;
  logic [31:0] inst_addr_r;

  // Only stall[1] matters to the fetch stage; the other stages' bits are
  // folded here so the full vector can still be wired straight through.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  // A fetch can start only from IDLE, with a valid PC, outside a flush,
  // and only when the PC is not already known to be misaligned.
  logic fetch_start;
  assign fetch_start = (state == IDLE) && pc_ce && !flush && !pc_except[ADEL_BIT];

  // The PC must hold from the cycle the request is decided until the data
  // has returned. The AdEL path completes in one edge, so it needs no hold.
  // In DONE the output register is the only holder, and stall[1] covers it.
  assign stallreq = fetch_start || (state == ADDR) || (state == DATA);

  assign bus.inst_req  = inst_req_r;
  assign bus.inst_addr = inst_addr_r;

  // Single sequencer: the state register and every registered output are
  // updated together, so inst_req and if_valid are clean state decodes
  // with no combinational path from the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cancel      <= 1'b0;
      inst_req_r  <= 1'b0;
      inst_addr_r <= 32'h0;
      if_valid    <= 1'b0;
      if_pc       <= RESET_PC;
      if_inst     <= 32'h0;
      if_except   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_ce && !flush) begin
            if (!pc_except[ADEL_BIT]) begin
              state       <= ADDR;
              inst_req_r  <= 1'b1;
              inst_addr_r <= pc;
            end else begin
              // Misaligned fetch: skip the bus entirely, deliver the fault.
              state     <= DONE;
              if_valid  <= 1'b1;
              if_pc     <= pc;
              if_inst   <= 32'h0;
              if_except <= pc_except;
            end
          end
        end

        ADDR: begin
          // The request stays up even through a flush. The bridge may
          // already be committed to it, so a flush only marks the data
          // as unwanted.
          if (flush) begin
            cancel <= 1'b1;
          end
          if (bus.inst_addr_ok) begin
            state      <= DATA;
            inst_req_r <= 1'b0;
          end
        end

        DATA: begin
          if (bus.inst_data_ok) begin
            if (cancel || flush) begin
              // Stale return: drop it. The cancel flag is cleared here, so
              // the next fetch starts clean.
              state  <= IDLE;
              cancel <= 1'b0;
            end else begin
              state     <= DONE;
              if_valid  <= 1'b1;
              if_pc     <= inst_addr_r;
              if_inst   <= bus.inst_rdata;
              if_except <= 32'h0;
            end
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end

        DONE: begin
          // A flush kills the held instruction even while it is stalled.
          // Otherwise the instruction leaves once stall[1] is released.
          if (flush || !stall[1]) begin
            state    <= IDLE;
            if_valid <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          cancel     <= 1'b0;
          inst_req_r <= 1'b0;
          if_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//
// Purpose:
//   Directed bench for if_fetch_ctrl. The bench plays both the PC register
//   and the instruction bridge. Inputs change just after a falling edge.
//   Outputs are checked on the following falling edge, half a cycle away
//   from the rising edge that updates the design.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hbfbf_fffc;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        pc_ce;
  logic [31:0] pc;
  logic [31:0] pc_except;
  logic        stallreq;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_except;

  int checks;
  int failures;

  if_fetch_ctrl_if bus ();

  if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .pc_ce     (pc_ce),
    .pc        (pc),
    .pc_except (pc_except),
    .stallreq  (stallreq),
    .bus       (bus.master),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_except (if_except)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full cycle: the design updates on the rising edge, and the bench
  // resumes on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives a clean fetch from IDLE to DONE with single-cycle bridge
  // responses. It only produces stimulus; callers do their own checking.
  task automatic fetch_to_done(input logic [31:0] addr, input logic [31:0] rdata);
    pc = addr; pc_ce = 1'b1; pc_except = 32'h0;
    tick();
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = rdata;
    tick();
    bus.inst_data_ok = 1'b0;
    pc_ce = 1'b0;
  endtask

  // Leaves the design in IDLE with nothing pending.
  task automatic drain();
    pc_ce = 1'b0; flush = 1'b0; stall = 6'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({stallreq, bus.inst_req, if_valid} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_ctl: got stallreq/req/valid=%b required 000", {stallreq, bus.inst_req, if_valid});
    end
    checks++;
    if (if_pc !== RESET_PC || if_inst !== 32'h0 || if_except !== 32'h0 || bus.inst_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got pc=%h inst=%h exc=%h addr=%h required %h/0/0/0",
               if_pc, if_inst, if_except, bus.inst_addr, RESET_PC);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    pc = 32'hbfc0_0000; pc_ce = 1'b1; pc_except = 32'h0;
    #1;
    checks++;
    if (stallreq !== 1'b1 || bus.inst_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_idle: got stallreq=%b req=%b required 1 0", stallreq, bus.inst_req);
    end
    tick();
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc0_0000) begin
      failures++;
      $display("[TB] FAIL basic_req: got req=%b addr=%h required 1 bfc00000", bus.inst_req, bus.inst_addr);
    end
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    checks++;
    if (bus.inst_req !== 1'b0 || stallreq !== 1'b1 || if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_data: got req=%b stallreq=%b valid=%b required 0 1 0", bus.inst_req, stallreq, if_valid);
    end
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h2408_0001;
    tick();
    bus.inst_data_ok = 1'b0;
    pc_ce = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b1 || if_inst !== 32'h2408_0001 || if_pc !== 32'hbfc0_0000 ||
        if_except !== 32'h0 || stallreq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done: got valid=%b inst=%h pc=%h exc=%h stallreq=%b required 1 24080001 bfc00000 0 0",
               if_valid, if_inst, if_pc, if_except, stallreq);
    end
    tick();
    checks++;
    if (if_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_consumed: got valid=%b req=%b required 0 0", if_valid, bus.inst_req);
    end
    drain();
  endtask

  task automatic test_adel();
    pc = 32'hbfc0_0002; pc_ce = 1'b1; pc_except = 32'h0001_0000;
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL adel_stallreq: got %b required 0", stallreq);
    end
    tick();
    pc_ce = 1'b0;
    checks++;
    if (bus.inst_req !== 1'b0 || if_valid !== 1'b1 || if_inst !== 32'h0 ||
        if_except !== 32'h0001_0000 || if_pc !== 32'hbfc0_0002) begin
      failures++;
      $display("[TB] FAIL adel_done: got req=%b valid=%b inst=%h exc=%h pc=%h required 0 1 0 00010000 bfc00002",
               bus.inst_req, if_valid, if_inst, if_except, if_pc);
    end
    pc_except = 32'h0;
    drain();
  endtask

  task automatic test_flush_data();
    pc = 32'hbfc0_0100; pc_ce = 1'b1; pc_except = 32'h0;
    tick();
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0; pc = 32'hbfc0_0380;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hdead_beef;
    #1;
    checks++;
    if (stallreq !== 1'b1 || if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flushd_wait: got stallreq=%b valid=%b required 1 0", stallreq, if_valid);
    end
    tick();
    bus.inst_data_ok = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || bus.inst_req !== 1'b0 || stallreq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flushd_discard: got valid=%b req=%b stallreq=%b required 0 0 1", if_valid, bus.inst_req, stallreq);
    end
    tick();
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc0_0380) begin
      failures++;
      $display("[TB] FAIL flushd_refetch_req: got req=%b addr=%h required 1 bfc00380", bus.inst_req, bus.inst_addr);
    end
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3c08_bfc0;
    tick();
    bus.inst_data_ok = 1'b0; pc_ce = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_inst !== 32'h3c08_bfc0 || if_pc !== 32'hbfc0_0380) begin
      failures++;
      $display("[TB] FAIL flushd_refetch_done: got valid=%b inst=%h pc=%h required 1 3c08bfc0 bfc00380", if_valid, if_inst, if_pc);
    end
    drain();
  endtask

  task automatic test_flush_addr();
    pc = 32'hbfc0_0200; pc_ce = 1'b1; pc_except = 32'h0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; pc = 32'hbfc0_0380;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc0_0200) begin
        failures++;
        $display("[TB] FAIL flusha_hold[%0d]: got req=%b addr=%h required 1 bfc00200", i, bus.inst_req, bus.inst_addr);
      end
      if (i < 2) tick();
    end
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1234_5678;
    pc_ce = 1'b0;
    tick();
    bus.inst_data_ok = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || if_inst === 32'h1234_5678 || bus.inst_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flusha_discard: got valid=%b inst=%h req=%b required 0 !=12345678 0", if_valid, if_inst, bus.inst_req);
    end
    drain();
  endtask

  task automatic test_flush_with_data();
    pc = 32'hbfc0_0300; pc_ce = 1'b1; pc_except = 32'h0;
    tick();
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hcafe_f00d; flush = 1'b1;
    pc = 32'hbfc0_0380;
    tick();
    bus.inst_data_ok = 1'b0; flush = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || if_inst === 32'hcafe_f00d) begin
      failures++;
      $display("[TB] FAIL flushsame_discard: got valid=%b inst=%h required 0 !=cafef00d", if_valid, if_inst);
    end
    // The cancel flag must not leak into this fetch.
    fetch_to_done(32'hbfc0_0380, 32'h0000_0000);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hbfc0_0380 || if_inst !== 32'h0) begin
      failures++;
      $display("[TB] FAIL flushsame_next: got valid=%b pc=%h inst=%h required 1 bfc00380 0", if_valid, if_pc, if_inst);
    end
    drain();
  endtask

  task automatic test_stall();
    fetch_to_done(32'hbfc0_0400, 32'h0000_0021);
    stall = 6'b000010; pc_ce = 1'b1; pc = 32'hbfc0_0404;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (if_valid !== 1'b1 || if_inst !== 32'h0000_0021 || if_pc !== 32'hbfc0_0400 || bus.inst_req !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b inst=%h pc=%h req=%b required 1 00000021 bfc00400 0",
                 i, if_valid, if_inst, if_pc, bus.inst_req);
      end
    end
    stall = 6'b0;
    tick();
    checks++;
    if (if_valid !== 1'b0 || stallreq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release: got valid=%b stallreq=%b required 0 1", if_valid, stallreq);
    end
    tick();
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc0_0404) begin
      failures++;
      $display("[TB] FAIL stall_next_req: got req=%b addr=%h required 1 bfc00404", bus.inst_req, bus.inst_addr);
    end
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h0;
    pc_ce = 1'b0;
    tick();
    drain();
  endtask

  task automatic test_flush_done_stalled();
    pc = 32'hbfc0_0006; pc_ce = 1'b1; pc_except = 32'h0001_0000;
    tick();
    pc_ce = 1'b0; pc_except = 32'h0;
    stall = 6'b000010; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_done: got valid=%b required 0", if_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    pc = 32'hbfc0_0500; pc_ce = 1'b1; pc_except = 32'h0;
    tick();
    rst = 1'b1; pc_ce = 1'b0;
    tick();
    checks++;
    if (bus.inst_req !== 1'b0 || if_valid !== 1'b0 || stallreq !== 1'b0 || bus.inst_addr !== 32'h0 ||
        if_pc !== RESET_PC || if_inst !== 32'h0 || if_except !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid: got req=%b valid=%b stallreq=%b addr=%h pc=%h inst=%h exc=%h required reset values",
               bus.inst_req, if_valid, stallreq, bus.inst_addr, if_pc, if_inst, if_except);
    end
    rst = 1'b0;
    fetch_to_done(32'hbfc0_0600, 32'h2402_0005);
    checks++;
    if (if_valid !== 1'b1 || if_inst !== 32'h2402_0005 || if_pc !== 32'hbfc0_0600) begin
      failures++;
      $display("[TB] FAIL reset_after: got valid=%b inst=%h pc=%h required 1 24020005 bfc00600", if_valid, if_inst, if_pc);
    end
    drain();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; stall = 6'b0; flush = 1'b0; pc_ce = 1'b0;
    pc = 32'h0; pc_except = 32'h0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_adel();
    test_flush_data();
    test_flush_addr();
    test_flush_with_data();
    test_stall();
    test_flush_done_stalled();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so a wedged run still terminates with a visible failure.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no summary, required summary before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
